// File: rtl/fft_support_blocks_pkg.sv
// Shared constants, types and the twiddle generator for the FFT support wrapper.
// The twiddle function uses only integer arithmetic, so the ROM is built during elaboration.
package fft_support_blocks_pkg;

  localparam int N         = 1024;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int TW_W      = 17;
  localparam int TW_SCALE  = 32768;
  localparam int DB_CYCLES = 16;
  localparam int TW_DEPTH  = N / 2;
  localparam int TW_IDX_W  = 9;

  typedef logic [TW_IDX_W-1:0] tw_index_t;

  // pi in unsigned Q60 fixed point (the leading hex digits of pi)
  localparam int          TW_FRAC = 60;
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  // round(-TW_SCALE * sin(2*pi*k/N)), half away from zero. The angle is folded into
  // [0, pi/2] and a Taylor series runs in 128-bit Q60, far below any rounding tie.
  function automatic logic signed [TW_W-1:0] twiddle_im(input int k);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] sum;
    logic [127:0] scaled;
    int           kq;
    kq   = (k > N / 4) ? (N / 2 - k) : k;
    x    = (PI_Q60 * 128'(kq)) >> $clog2(N / 2);
    x2   = (x * x) >> TW_FRAC;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = (term * x2) >> TW_FRAC;
      term = term / 128'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    scaled = (sum * 128'(TW_SCALE) + (128'(1) << (TW_FRAC - 1))) >> TW_FRAC;
    return -$signed(scaled[TW_W-1:0]);
  endfunction

endpackage

// File: rtl/fft_dp_ram.sv
// True dual-port 1024x32 data memory with registered reads and read-old-data behaviour.
// When both ports write one address in the same cycle, port B's data is kept.
module fft_dp_ram
  import fft_support_blocks_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              wren_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              wren_b,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem [N];

  // Port B is written after port A so it wins an address collision.
  always_ff @(posedge clk) begin
    if (wren_a) mem[address_a] <= data_a;
    if (wren_b) mem[address_b] <= data_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= mem[address_a];
      q_b <= mem[address_b];
    end
  end

endmodule

// File: rtl/fft_support_blocks.sv
// FFT support wrapper: enable debouncer, one dual-port data RAM and the imaginary twiddle ROM.
// The three functions share only clock and reset.
module fft_support_blocks
  import fft_support_blocks_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bin,
  output logic                   bout,
  input  logic [ADDR_W-1:0]      address_a,
  input  logic [DATA_W-1:0]      data_a,
  input  logic                   wren_a,
  output logic [DATA_W-1:0]      q_a,
  input  logic [ADDR_W-1:0]      address_b,
  input  logic [DATA_W-1:0]      data_b,
  input  logic                   wren_b,
  output logic [DATA_W-1:0]      q_b,
  input  tw_index_t              rom_address,
  output logic signed [TW_W-1:0] rom_q
);

  localparam int DB_CNT_W = $clog2(DB_CYCLES);

  logic                sync_0;
  logic                sync_1;
  logic [DB_CNT_W-1:0] db_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
    end else begin
      sync_0 <= bin;
      sync_1 <= sync_0;
    end
  end

  // bout follows only after DB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bout     <= 1'b0;
      db_count <= '0;
    end else if (sync_1 != bout) begin
      if (db_count == DB_CNT_W'(DB_CYCLES - 1)) begin
        bout     <= sync_1;
        db_count <= '0;
      end else begin
        db_count <= db_count + 1'b1;
      end
    end else begin
      db_count <= '0;
    end
  end

  fft_dp_ram u_ram (
    .clk       (clk),
    .rst       (rst),
    .address_a (address_a),
    .data_a    (data_a),
    .wren_a    (wren_a),
    .q_a       (q_a),
    .address_b (address_b),
    .data_b    (data_b),
    .wren_b    (wren_b),
    .q_b       (q_b)
  );

  logic signed [TW_W-1:0] tw_table [TW_DEPTH];

  for (genvar k = 0; k < TW_DEPTH; k++) begin : g_tw
    localparam logic signed [TW_W-1:0] TW_VAL = twiddle_im(k);
    assign tw_table[k] = TW_VAL;
  end

  always_ff @(posedge clk) begin
    if (rst) rom_q <= '0;
    else     rom_q <= tw_table[rom_address];
  end

endmodule

// File: tb/tb_fft_support_blocks.sv
// Directed bench for fft_support_blocks: a behavioural model is compared every cycle,
// and literal expectations from hand calculation pin the model at key points.
module tb_fft_support_blocks;

  logic               clk = 1'b0;
  logic               rst;
  logic               bin;
  logic               bout;
  logic [9:0]         address_a;
  logic [31:0]        data_a;
  logic               wren_a;
  logic [31:0]        q_a;
  logic [9:0]         address_b;
  logic [31:0]        data_b;
  logic               wren_b;
  logic [31:0]        q_b;
  logic [8:0]         rom_address;
  logic signed [16:0] rom_q;

  int checks   = 0;
  int failures = 0;

  fft_support_blocks dut (
    .clk         (clk),
    .rst         (rst),
    .bin         (bin),
    .bout        (bout),
    .address_a   (address_a),
    .data_a      (data_a),
    .wren_a      (wren_a),
    .q_a         (q_a),
    .address_b   (address_b),
    .data_b      (data_b),
    .wren_b      (wren_b),
    .q_b         (q_b),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  function automatic int rom_model(input int k);
    real v;
    v = 32768.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
    return -$rtoi(v + 0.5);
  endfunction

  // Behavioural model: bin reaches the debouncer two edges late; bout flips after
  // 16 consecutive disagreeing samples. RAM reads see contents before this edge's writes.
  logic [31:0] mem_m [1024];
  logic        h1 = 1'b0;
  logic        h2 = 1'b0;
  logic        s_now;
  int          run = 0;
  logic        m_bout = 1'b0;
  logic [31:0] m_q_a = '0;
  logic [31:0] m_q_b = '0;
  int          m_rom = 0;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  bit          started = 1'b0;

  initial for (int i = 0; i < 1024; i++) mem_m[i] = '0;

  always @(posedge clk) begin
    started = 1'b1;
    s_now = h2;
    h2 = h1;
    h1 = bin;
    if (rst) begin
      h1 = 1'b0;
      h2 = 1'b0;
      m_bout = 1'b0;
      run = 0;
    end else if (s_now != m_bout) begin
      run++;
      if (run == 16) begin
        m_bout = s_now;
        run = 0;
      end
    end else begin
      run = 0;
    end
    rd_a = mem_m[address_a];
    rd_b = mem_m[address_b];
    if (wren_a) mem_m[address_a] = data_a;
    if (wren_b) mem_m[address_b] = data_b;
    m_q_a = rst ? 32'd0 : rd_a;
    m_q_b = rst ? 32'd0 : rd_b;
    m_rom = rst ? 0 : rom_model(int'(rom_address));
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model_bout", 32'(bout), 32'(m_bout));
      checkOutput("model_q_a", q_a, m_q_a);
      checkOutput("model_q_b", q_b, m_q_b);
      checkOutput("model_rom_q", 32'(signed'(rom_q)), 32'(m_rom));
    end
  end

  int rom_addr_tab [5] = '{0, 128, 256, 384, 511};
  int rom_exp_tab  [5] = '{0, -23170, -32768, -23170, -201};

  initial begin
    rst = 1'b1;
    bin = 1'b0;
    address_a = '0;
    data_a = '0;
    wren_a = 1'b0;
    address_b = '0;
    data_b = '0;
    wren_b = 1'b0;
    rom_address = '0;
    @(negedge clk);
    applyStimulus(3);
    checkOutput("reset_bout", 32'(bout), 32'd0);
    checkOutput("reset_q_a", q_a, 32'd0);
    checkOutput("reset_q_b", q_b, 32'd0);
    checkOutput("reset_rom_q", 32'(signed'(rom_q)), 32'd0);
    rst = 1'b0;

    bin = 1'b1;
    applyStimulus(5);
    bin = 1'b0;
    applyStimulus(25);
    checkOutput("glitch_5_bout", 32'(bout), 32'd0);

    bin = 1'b1;
    applyStimulus(17);
    checkOutput("edge_plus_17_bout", 32'(bout), 32'd0);
    applyStimulus(1);
    checkOutput("edge_plus_18_bout", 32'(bout), 32'd1);
    applyStimulus(22);
    bin = 1'b0;
    applyStimulus(3);
    bin = 1'b1;
    applyStimulus(20);
    checkOutput("dropout_3_bout", 32'(bout), 32'd1);

    address_a = 10'd5;
    data_a = 32'h7FFF_0001;
    wren_a = 1'b1;
    applyStimulus(1);
    wren_a = 1'b0;
    address_b = 10'd5;
    applyStimulus(1);
    checkOutput("portb_read_5", q_b, 32'h7FFF_0001);
    address_b = 10'd6;
    applyStimulus(1);
    checkOutput("unwritten_6", q_b, 32'd0);

    address_a = 10'd10;
    data_a = 32'(-3);
    wren_a = 1'b1;
    applyStimulus(1);
    data_a = 32'd42;
    applyStimulus(1);
    checkOutput("rdw_old_data", q_a, 32'(-3));
    wren_a = 1'b0;
    applyStimulus(1);
    checkOutput("rdw_new_data", q_a, 32'd42);

    address_a = 10'd20;
    address_b = 10'd20;
    data_a = 32'd1;
    data_b = 32'd2;
    wren_a = 1'b1;
    wren_b = 1'b1;
    applyStimulus(1);
    wren_a = 1'b0;
    wren_b = 1'b0;
    applyStimulus(1);
    checkOutput("collision_b_wins", q_a, 32'd2);

    for (int i = 0; i < 5; i++) begin
      rom_address = 9'(rom_addr_tab[i]);
      applyStimulus(1);
      checkOutput($sformatf("rom_%0d", rom_addr_tab[i]), 32'(signed'(rom_q)), 32'(rom_exp_tab[i]));
    end

    address_a = 10'd5;
    rom_address = 9'd256;
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("midreset_bout", 32'(bout), 32'd0);
    checkOutput("midreset_q_a", q_a, 32'd0);
    checkOutput("midreset_q_b", q_b, 32'd0);
    checkOutput("midreset_rom_q", 32'(signed'(rom_q)), 32'd0);
    rst = 1'b0;
    address_b = 10'd5;
    applyStimulus(1);
    checkOutput("post_reset_read_5", q_b, 32'h7FFF_0001);
    checkOutput("post_reset_rom_256", 32'(signed'(rom_q)), 32'(-32768));

    wren_a = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      address_a = 10'(i);
      data_a = 32'(i * 3);
      applyStimulus(1);
    end
    wren_a = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      address_b = 10'(i);
      applyStimulus(1);
      checkOutput($sformatf("depth_%0d", i), q_b, 32'(i * 3));
    end
    address_b = 10'd0;
    applyStimulus(1);
    checkOutput("depth_wrap_0", q_b, 32'd0);
    address_b = 10'd1023;
    applyStimulus(1);
    checkOutput("depth_wrap_1023", q_b, 32'd3069);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_support_blocks.md
Name: fft_support_blocks

Overview:
- Support wrapper for the 1024-point radix-2 FFT core. It bundles three functions:
  - a push-button/enable debouncer;
  - a true dual-port 1024x32 signed data memory (one instance per real or imaginary plane);
  - the 512-entry imaginary twiddle ROM.
- The FFT controller drives all three directly; no logic is shared between the functions except clock and reset.

Parameters:
- N, 1024, FFT length; memory depth N, ROM depth N/2.
- DATA_W, 32, RAM word width, signed.
- TW_W, 17, twiddle width, signed; must hold +/-32768.
- DB_CYCLES, 16, consecutive stable cycles required before the debounced output changes.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- bin  in  1  raw (bouncy) enable/button input.
- bout  out  1  debounced level of bin.
- address_a  in  10  RAM port A address.
- data_a  in  32  RAM port A write data.
- wren_a  in  1  RAM port A write enable.
- q_a  out  32  RAM port A read data.
- address_b  in  10  RAM port B address.
- data_b  in  32  RAM port B write data.
- wren_b  in  1  RAM port B write enable.
- q_b  out  32  RAM port B read data.
- rom_address  in  9  twiddle index k, 0..511.
- rom_q  out  17  signed imaginary twiddle value.

Behaviour:
- Reset values: bout=0, q_a=0, q_b=0, rom_q=0, debounce counter=0. RAM contents are not cleared by reset; power-up contents are all zero.
- Debouncer:
  - Two-flop synchroniser on bin, then a stability counter.
  - When the synchronised input differs from bout, the counter increments; otherwise it clears.
  - When the counter reaches DB_CYCLES-1 while still differing, bout takes the new value and the counter clears.
  - Output is a level, not a pulse. Total latency from a clean edge is 2+DB_CYCLES cycles.
  - Any glitch shorter than DB_CYCLES cycles never reaches bout.
- RAM:
  - Registered read with 1-cycle latency: q_x in cycle t+1 holds mem[address_x] sampled at edge t.
  - Write when wren_x=1 at the edge.
  - Same-port read-during-write returns the old data.
  - Cross-port read of an address written in the same cycle also returns the old data.
  - Both ports writing the same address in the same cycle: port B's data is stored.
  - Addresses are 10 bits; the controller must not present addresses of 1024 or above, because upper bits are truncated.
- ROM:
  - Registered with 1-cycle latency: rom_q = round(-32768*sin(2*pi*k/1024)), signed 17-bit, round half away from zero.
  - Range is -32768..0 for k=0..511.
  - Contents are computed at elaboration (real sine, rounded), or loaded from a generated hex file with identical values.
  - rst only clears the output register; the next read is valid immediately after reset.
- The three functions are independent; simultaneous activity on all of them is legal.

Decomposition:
- Shared package: N, ADDR_W=10, DATA_W=32, TW_W=17, TW_SCALE=32768, and a twiddle-index typedef (9 bits).
- One natural sub-module: fft_dp_ram (dual-port RAM). The wrapper instantiates it once; the FFT instantiates two wrappers or RAMs, one for the real plane and one for the imaginary plane.
- The debouncer and ROM stay inline.

Test Plan:
- Debounce:
  - Reset, then bin pulses high for 5 cycles -> bout stays 0.
  - bin held high for 40 cycles -> bout rises exactly 2+16 cycles after the edge.
  - bin drops for 3 cycles, then returns high -> bout stays 1.
- RAM write/read:
  - Port A writes 0x7FFF_0001 at address 5.
  - Next cycle, port B reads address 5 -> q_b = 0x7FFF_0001 one cycle later.
  - Read address 6 (never written) -> 0.
- Read-during-write:
  - Address 10 holds -3; port A writes 42 there while reading address 10 -> q_a=-3 that cycle, then 42 on the following read.
  - Both ports write address 20 with A=1, B=2 -> a later read of address 20 returns 2.
- ROM sweep:
  - Address 0 -> 0; 128 -> -23170; 256 -> -32768; 384 -> -23170; 511 -> -201.
  - Each value appears one cycle after its address is applied.
- Reset mid-operation:
  - Assert rst with bout=1 and the RAM holding data -> bout, q_a, q_b and rom_q all read 0 after the reset edge.
  - A subsequent read of address 5 still returns 0x7FFF_0001.
- Full depth:
  - Write mem[i]=i*3 for i=0..1023 via port A.
  - Read back all entries via port B -> every value matches, with no wrap aliasing at addresses 1023 and 0.
